// File: rtl/wrr_pkt_sched.sv
// Weighted round-robin packet scheduler: grants one requester at a time for up to
// weight[i] packets, then releases with a one-cycle bubble and advances the pointer.
module wrr_pkt_sched #(
  parameter int unsigned PORTS        = 4,
  parameter int unsigned WEIGHT_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORTS-1:0]                request,
  input  logic [PORTS*WEIGHT_WIDTH-1:0]   weight,
  input  logic                            pkt_done,
  output logic [PORTS-1:0]                grant,
  output logic                            grant_valid,
  output logic [$clog2(PORTS)-1:0]        grant_encoded
);

  localparam int unsigned PTR_W = $clog2(PORTS);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]              state, state_n;
  logic [PTR_W-1:0]        rr_ptr, rr_ptr_n;
  logic [WEIGHT_WIDTH-1:0] credit, credit_n;
  logic [WEIGHT_WIDTH-1:0] credit_dec, sel_weight;
  logic [PORTS-1:0]        eligible, grant_n;
  logic                    grant_valid_n;
  logic [PTR_W-1:0]        enc_n;
  logic [PTR_W-1:0]        sel, sel_hi, sel_lo, next_ptr;
  logic                    found_hi, found_lo;
  logic                    granted_req;

  // A port competes only if it is requesting and has a non-zero quantum
  always_comb begin
    eligible = '0;
    for (int i = 0; i < PORTS; i++) begin
      eligible[i] = request[i] && (weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
    end
  end

  // Circular search: lowest eligible index at or above rr_ptr, else lowest overall
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found_lo = 1'b1;
        sel_lo   = PTR_W'(i);
        if (PTR_W'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          sel_hi   = PTR_W'(i);
        end
      end
    end
  end

  assign sel = found_hi ? sel_hi : sel_lo;

  always_comb begin
    sel_weight = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (sel == PTR_W'(i)) sel_weight = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  assign credit_dec  = credit - WEIGHT_WIDTH'(1);
  assign granted_req = |(request & grant);
  assign next_ptr    = (grant_encoded == PTR_W'(PORTS - 1)) ? '0 : grant_encoded + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      credit        <= '0;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
    end else begin
      state         <= state_n;
      rr_ptr        <= rr_ptr_n;
      credit        <= credit_n;
      grant         <= grant_n;
      grant_valid   <= grant_valid_n;
      grant_encoded <= enc_n;
    end
  end

  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    credit_n      = credit;
    grant_n       = grant;
    grant_valid_n = grant_valid;
    enc_n         = grant_encoded;
    case (state)
      IDLE: begin
        if (found_lo) begin
          state_n       = GRANT;
          grant_n       = PORTS'(1) << sel;
          grant_valid_n = 1'b1;
          enc_n         = sel;
          credit_n      = sel_weight;
        end else begin
          grant_n       = '0;
          grant_valid_n = 1'b0;
          enc_n         = '0;
        end
      end
      GRANT: begin
        // Hold for the whole packet; only a completed packet can consume credit
        if (pkt_done) begin
          credit_n = credit_dec;
          if (credit_dec == '0 || !granted_req) begin
            state_n       = IDLE;
            grant_n       = '0;
            grant_valid_n = 1'b0;
            enc_n         = '0;
            rr_ptr_n      = next_ptr;
          end
        end
      end
      default: begin
        state_n       = IDLE;
        grant_n       = '0;
        grant_valid_n = 1'b0;
        enc_n         = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wrr_pkt_sched.sv
// Bench for wrr_pkt_sched: vector table, directed corner sequences, and a random
// run against a queue-free arithmetic reference model.
module tb_wrr_pkt_sched;

  localparam int unsigned PORTS = 4;
  localparam int unsigned WW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  request;
  logic [15:0] weight;
  logic        pkt_done;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_encoded;

  int checks = 0;
  int errors = 0;

  bit m_busy;
  int m_port, m_credit, m_ptr;

  wrr_pkt_sched #(.PORTS(PORTS), .WEIGHT_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .request(request), .weight(weight), .pkt_done(pkt_done),
    .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] w;
    logic        pd;
    logic [3:0]  g;
    logic        v;
    logic [1:0]  e;
  } vec_t;

  vec_t tbl[15];

  // Reference: scheduler rules applied with plain integer arithmetic
  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_credit = 0; m_port = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < int'(PORTS); k++) begin
        int p;
        p = (m_ptr + k) % int'(PORTS);
        if (request[p] && weight[p*WW +: WW] != 0) begin
          m_busy = 1; m_port = p; m_credit = int'(weight[p*WW +: WW]);
          break;
        end
      end
    end else if (pkt_done) begin
      m_credit = m_credit - 1;
      if (m_credit == 0 || !request[m_port]) begin
        m_busy = 0;
        m_ptr  = (m_port + 1) % int'(PORTS);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] q, input logic [15:0] w, input logic pd);
    rst = r; request = q; weight = w; pkt_done = pd;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [3:0] g, input logic v, input logic [1:0] e);
    checks++;
    if (grant !== g || grant_valid !== v || grant_encoded !== e) begin
      errors++;
      $display("FAIL %s: got grant=%b valid=%b enc=%0d, expected grant=%b valid=%b enc=%0d",
               name, grant, grant_valid, grant_encoded, g, v, e);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] eg;
    eg = m_busy ? 4'(1 << m_port) : 4'b0;
    check_out(name, eg, m_busy, m_busy ? 2'(m_port) : 2'd0);
    checks++;
    if (!$onehot0(grant) || (grant_valid != (grant != 4'b0))) begin
      errors++;
      $display("FAIL %s_invariant: got grant=%b valid=%b, expected one-hot/zero with valid matching",
               name, grant, grant_valid);
    end
  endtask

  initial begin
    // Equal weights round-robin, then weight-0 port and pkt_done while idle
    tbl[0]  = '{1'b1, 4'hf, 16'h1111, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 4'hf, 16'h1111, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[2]  = '{1'b0, 4'hf, 16'h1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[3]  = '{1'b0, 4'hf, 16'h1111, 1'b0, 4'b0010, 1'b1, 2'd1};
    tbl[4]  = '{1'b0, 4'hf, 16'h1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[5]  = '{1'b0, 4'hf, 16'h1111, 1'b0, 4'b0100, 1'b1, 2'd2};
    tbl[6]  = '{1'b0, 4'hf, 16'h1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[7]  = '{1'b0, 4'hf, 16'h1111, 1'b0, 4'b1000, 1'b1, 2'd3};
    tbl[8]  = '{1'b0, 4'hf, 16'h1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[9]  = '{1'b0, 4'hf, 16'h1111, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[10] = '{1'b0, 4'hf, 16'h1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[11] = '{1'b0, 4'h4, 16'h1011, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[12] = '{1'b0, 4'h4, 16'h1011, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[13] = '{1'b0, 4'h4, 16'h1011, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[14] = '{1'b0, 4'h0, 16'h1011, 1'b1, 4'b0000, 1'b0, 2'd0};

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].w, tbl[i].pd);
      check_out($sformatf("tbl%0d", i), tbl[i].g, tbl[i].v, tbl[i].e);
    end

    // Weights {3,1}: port 0 held for three packets, then port 1, then port 0
    cyc(1'b1, 4'b0011, 16'h0013, 1'b0); check_out("w31_rst", 4'b0000, 1'b0, 2'd0);
    cyc(1'b0, 4'b0011, 16'h0013, 1'b0); check_out("w31_g0", 4'b0001, 1'b1, 2'd0);
    cyc(1'b0, 4'b0011, 16'h0013, 1'b1); check_out("w31_hold1", 4'b0001, 1'b1, 2'd0);
    cyc(1'b0, 4'b0011, 16'h0013, 1'b1); check_out("w31_hold2", 4'b0001, 1'b1, 2'd0);
    cyc(1'b0, 4'b0011, 16'h0013, 1'b1); check_out("w31_rel0", 4'b0000, 1'b0, 2'd0);
    cyc(1'b0, 4'b0011, 16'h0013, 1'b0); check_out("w31_g1", 4'b0010, 1'b1, 2'd1);
    cyc(1'b0, 4'b0011, 16'h0013, 1'b1); check_out("w31_rel1", 4'b0000, 1'b0, 2'd0);
    cyc(1'b0, 4'b0011, 16'h0013, 1'b0); check_out("w31_g0_again", 4'b0001, 1'b1, 2'd0);

    // Request drops mid-packet: hold until pkt_done, then pointer moves to 2
    cyc(1'b1, 4'b0010, 16'h0040, 1'b0); check_out("drop_rst", 4'b0000, 1'b0, 2'd0);
    cyc(1'b0, 4'b0010, 16'h0040, 1'b0); check_out("drop_g1", 4'b0010, 1'b1, 2'd1);
    cyc(1'b0, 4'b0000, 16'h0040, 1'b0); check_out("drop_hold", 4'b0010, 1'b1, 2'd1);
    cyc(1'b0, 4'b0000, 16'h0040, 1'b0); check_out("drop_hold2", 4'b0010, 1'b1, 2'd1);
    cyc(1'b0, 4'b0000, 16'h0040, 1'b1); check_out("drop_rel", 4'b0000, 1'b0, 2'd0);
    cyc(1'b0, 4'b1111, 16'h1111, 1'b0); check_out("drop_ptr2", 4'b0100, 1'b1, 2'd2);

    // Reset mid-grant discards pkt_done and restarts search from port 0
    cyc(1'b1, 4'b1000, 16'h2222, 1'b0); check_out("mrst_rst", 4'b0000, 1'b0, 2'd0);
    cyc(1'b0, 4'b1000, 16'h2222, 1'b0); check_out("mrst_g3", 4'b1000, 1'b1, 2'd3);
    cyc(1'b1, 4'b1000, 16'h2222, 1'b1); check_out("mrst_drop", 4'b0000, 1'b0, 2'd0);
    cyc(1'b0, 4'b1001, 16'h2222, 1'b0); check_out("mrst_g0", 4'b0001, 1'b1, 2'd0);

    // Random run against the reference model
    begin
      logic [15:0] w;
      w = 16'h1111;
      cyc(1'b1, 4'b0000, w, 1'b0);
      check_model("rnd_rst");
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 7) == 0) begin
          for (int p = 0; p < 4; p++) w[p*4 +: 4] = 4'($urandom_range(0, 3));
        end
        cyc(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), w,
            1'($urandom_range(0, 1)));
        check_model($sformatf("rnd%0d", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrr_pkt_sched.md
WRR_PKT_SCHED -- requirements
Module: wrr_pkt_sched

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requesters, 2..32.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 4: bits per port weight.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port request, input, PORTS: bit i set means port i has a packet pending.
REQ-006 SHALL have port weight, input, PORTS*WEIGHT_WIDTH: packet quantum per port; port i uses bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-007 SHALL have port pkt_done, input, 1: one-cycle pulse when the granted port completes a packet (last-beat handshake on the shared output).
REQ-008 SHALL have port grant, output, PORTS: one-hot grant, registered.
REQ-009 SHALL have port grant_valid, output, 1: grant is meaningful.
REQ-010 SHALL have port grant_encoded, output, $clog2(PORTS): index of the granted port.

Function
REQ-011 SHALL implement two states, IDLE and GRANT, plus registers rr_ptr ($clog2(PORTS) bits) and credit (WEIGHT_WIDTH bits).
REQ-012 Eligible port: request[i]=1 and weight_i != 0; ports with weight 0 SHALL never be granted.
REQ-013 In IDLE, select the first eligible port searching circularly rr_ptr, rr_ptr+1, ..., wrapping PORTS-1 to 0.
REQ-014 In IDLE with at least one eligible port, the next cycle SHALL be GRANT with grant/grant_encoded set to the selected port, grant_valid=1, and credit=weight of that port, sampled at that edge.
REQ-015 Latency: request to grant_valid SHALL be exactly 1 cycle from IDLE.
REQ-016 In IDLE with no eligible port, SHALL remain IDLE with grant=0, grant_valid=0, grant_encoded=0.
REQ-017 In GRANT without pkt_done, grant SHALL be held unchanged, even if request of the granted port deasserts (packet-level hold).
REQ-018 In GRANT with pkt_done: credit decrements by 1. If the decremented credit is 0 or request[granted]=0 in that cycle, SHALL release. Otherwise the grant SHALL be held.
REQ-019 Release: next cycle SHALL be IDLE with grant=0, grant_valid=0, rr_ptr = granted index + 1, wrapping PORTS-1 to 0. This gives exactly one bubble cycle between grants.
REQ-020 pkt_done in IDLE SHALL be ignored; credit and rr_ptr are unchanged.
REQ-021 Changes to weight during GRANT SHALL NOT affect the current credit; the new value applies at the next grant.
REQ-022 credit SHALL never underflow; 0 is reached only through release.
REQ-023 Single eligible requester that keeps requesting SHALL be re-granted after each bubble, since the circular search wraps back to it.
REQ-024 grant SHALL always be one-hot or zero, and grant_valid=1 iff grant != 0.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, rr_ptr=0, credit=0, grant=0, grant_valid=0, grant_encoded=0.
REQ-026 Reset asserted mid-GRANT SHALL drop grant on the next edge; a pending pkt_done in that cycle SHALL be discarded.
REQ-027 On the first cycle after reset release, arbitration SHALL start from port 0.

Verification
REQ-028 PORTS=4, weights {1,1,1,1}, request=4'b1111, pkt_done one cycle after each grant -> grant order 0,1,2,3,0 with one bubble cycle between grants.
REQ-029 Weights {3,1,0,0}, request=4'b0011, pkt_done each grant cycle -> port 0 is held for 3 pkt_done pulses, bubble, port 1 for 1 pulse, bubble, port 0 again.
REQ-030 Weight 0 for port 2, request=4'b0100 only -> grant_valid stays 0 indefinitely.
REQ-031 Port 1 granted with weight 4, request[1] deasserts before the first pkt_done -> grant held until pkt_done, then release; rr_ptr=2.
REQ-032 rst pulsed while port 3 is granted with credit 2 -> next cycle grant=0, grant_valid=0; after release with request=4'b1001, port 0 is granted first.
REQ-033 pkt_done pulsed while IDLE with request=0 -> no state change; a random stimulus run SHALL check the one-hot/grant_valid invariant every cycle.
